// File: rtl/pin_entry_controller.sv
// ATM login front end: latches the card's account, collects a decimal PIN,
// runs the authenticator handshake and tracks retries, lockout and timeout.
module pin_entry_controller #(
  parameter int PIN_DIGITS   = 4,
  parameter int MAX_ATTEMPTS = 3,
  parameter int AUTH_TIMEOUT = 16,
  parameter int NUM_ACCOUNTS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_valid,
  input  logic [3:0]  card_acc_num,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        key_enter,
  input  logic        key_clear,
  output logic        auth_req,
  output logic [3:0]  auth_acc_num,
  output logic [15:0] auth_pin,
  input  logic        auth_done,
  input  logic        auth_ok,
  output logic [2:0]  digit_count,
  output logic [1:0]  attempts_left,
  output logic        session_valid,
  output logic [3:0]  session_acc_num,
  output logic        locked_out
);

  typedef enum logic [2:0] {IDLE, COLLECT, REQUEST, WAIT, GRANTED, LOCKED} state_t;

  localparam int             TW       = $clog2(AUTH_TIMEOUT + 1);
  localparam logic [2:0]     FULL     = 3'(PIN_DIGITS);
  localparam logic [1:0]     MAX_ATT  = 2'(MAX_ATTEMPTS);
  localparam logic [4:0]     NUM_ACC  = 5'(NUM_ACCOUNTS);
  localparam logic [TW-1:0]  TMO_LAST = TW'(AUTH_TIMEOUT - 1);

  state_t        state;
  logic          card_prev;
  logic [3:0]    acc_num;
  logic [13:0]   pin_acc;
  logic [TW-1:0] timer;

  // Shift one decimal digit into the binary PIN value (9999 fits in 14 bits).
  function automatic logic [13:0] next_acc(input logic [13:0] a, input logic [3:0] d);
    return 14'(a * 14'd10 + {10'd0, d});
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      card_prev       <= 1'b0;
      acc_num         <= '0;
      pin_acc         <= '0;
      timer           <= '0;
      auth_req        <= 1'b0;
      auth_acc_num    <= '0;
      auth_pin        <= '0;
      digit_count     <= '0;
      attempts_left   <= MAX_ATT;
      session_valid   <= 1'b0;
      session_acc_num <= '0;
      locked_out      <= 1'b0;
    end else begin
      card_prev <= card_valid;
      // Card removal overrides everything, including a same-cycle auth_done.
      if (!card_valid && state != IDLE) begin
        state           <= IDLE;
        acc_num         <= '0;
        pin_acc         <= '0;
        timer           <= '0;
        auth_req        <= 1'b0;
        auth_acc_num    <= '0;
        auth_pin        <= '0;
        digit_count     <= '0;
        attempts_left   <= MAX_ATT;
        session_valid   <= 1'b0;
        session_acc_num <= '0;
        locked_out      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (card_valid && !card_prev) begin
              acc_num       <= card_acc_num;
              attempts_left <= MAX_ATT;
              state         <= ({1'b0, card_acc_num} >= NUM_ACC) ? LOCKED : COLLECT;
            end
          end
          COLLECT: begin
            if (key_clear) begin
              pin_acc     <= '0;
              digit_count <= '0;
            end else if (key_enter && digit_count == FULL) begin
              auth_req     <= 1'b1;
              auth_acc_num <= acc_num;
              auth_pin     <= {2'b00, pin_acc};
              timer        <= '0;
              state        <= REQUEST;
            end else if (key_valid && key_digit <= 4'd9 && digit_count < FULL) begin
              pin_acc     <= next_acc(pin_acc, key_digit);
              digit_count <= digit_count + 3'd1;
            end
          end
          REQUEST, WAIT: begin
            if (auth_done && auth_ok) begin
              auth_req     <= 1'b0;
              auth_acc_num <= '0;
              auth_pin     <= '0;
              state        <= GRANTED;
            end else if (auth_done || timer == TMO_LAST) begin
              auth_req      <= 1'b0;
              auth_acc_num  <= '0;
              auth_pin      <= '0;
              pin_acc       <= '0;
              digit_count   <= '0;
              attempts_left <= attempts_left - 2'd1;
              state         <= (attempts_left == 2'd1) ? LOCKED : COLLECT;
            end else begin
              timer <= timer + TW'(1);
              state <= WAIT;
            end
          end
          GRANTED: begin
            session_valid   <= 1'b1;
            session_acc_num <= acc_num;
          end
          LOCKED: locked_out <= 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pin_entry_controller.sv
// Directed bench for pin_entry_controller: login, lockout, bad card, key
// editing, timeout, card removal and reset during a session.
module tb_pin_entry_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic        card_valid;
  logic [3:0]  card_acc_num;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        key_enter;
  logic        key_clear;
  logic        auth_req;
  logic [3:0]  auth_acc_num;
  logic [15:0] auth_pin;
  logic        auth_done;
  logic        auth_ok;
  logic [2:0]  digit_count;
  logic [1:0]  attempts_left;
  logic        session_valid;
  logic [3:0]  session_acc_num;
  logic        locked_out;

  int pass_cnt = 0;
  int total    = 0;

  pin_entry_controller dut (
    .clk(clk), .rst(rst), .card_valid(card_valid), .card_acc_num(card_acc_num),
    .key_valid(key_valid), .key_digit(key_digit), .key_enter(key_enter),
    .key_clear(key_clear), .auth_req(auth_req), .auth_acc_num(auth_acc_num),
    .auth_pin(auth_pin), .auth_done(auth_done), .auth_ok(auth_ok),
    .digit_count(digit_count), .attempts_left(attempts_left),
    .session_valid(session_valid), .session_acc_num(session_acc_num),
    .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic insert(input logic [3:0] acc);
    card_valid = 1'b1; card_acc_num = acc;
    tick();
  endtask

  task automatic remove();
    card_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic enter();
    key_enter = 1'b1;
    tick();
    key_enter = 1'b0;
  endtask

  task automatic respond(input logic ok);
    auth_done = 1'b1; auth_ok = ok;
    tick();
    auth_done = 1'b0; auth_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++; if (auth_req !== 1'b0) $display("FAIL reset_req actual=%0d required=0", auth_req); else pass_cnt++;
    total++; if (attempts_left !== 2'd3) $display("FAIL reset_attempts actual=%0d required=3", attempts_left); else pass_cnt++;
    total++; if (digit_count !== 3'd0) $display("FAIL reset_count actual=%0d required=0", digit_count); else pass_cnt++;
    total++; if ({session_valid, locked_out} !== 2'b00) $display("FAIL reset_flags actual=%b required=00", {session_valid, locked_out}); else pass_cnt++;
    total++; if (auth_pin !== 16'd0) $display("FAIL reset_pin actual=%0d required=0", auth_pin); else pass_cnt++;
  endtask

  task automatic test_grant();
    insert(4'd0);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    total++; if (digit_count !== 3'd4) $display("FAIL grant_count actual=%0d required=4", digit_count); else pass_cnt++;
    enter();
    total++; if (auth_req !== 1'b1) $display("FAIL grant_req actual=%0d required=1", auth_req); else pass_cnt++;
    total++; if (auth_pin !== 16'd1234) $display("FAIL grant_pin actual=%0d required=1234", auth_pin); else pass_cnt++;
    tick();
    total++; if (auth_req !== 1'b1) $display("FAIL grant_req_hold actual=%0d required=1", auth_req); else pass_cnt++;
    respond(1'b1);
    total++; if (auth_req !== 1'b0) $display("FAIL grant_req_drop actual=%0d required=0", auth_req); else pass_cnt++;
    total++; if (auth_pin !== 16'd0) $display("FAIL grant_pin_clear actual=%0d required=0", auth_pin); else pass_cnt++;
    tick();
    total++; if (session_valid !== 1'b1) $display("FAIL grant_session actual=%0d required=1", session_valid); else pass_cnt++;
    total++; if (session_acc_num !== 4'd0) $display("FAIL grant_acc actual=%0d required=0", session_acc_num); else pass_cnt++;
    remove();
    total++; if (session_valid !== 1'b0) $display("FAIL grant_remove actual=%0d required=0", session_valid); else pass_cnt++;
  endtask

  task automatic test_lockout();
    logic [1:0] exp_att;
    insert(4'd9);
    for (int i = 0; i < 3; i++) begin
      press(4'd1); press(4'd1); press(4'd1); press(4'd1);
      enter();
      total++; if (auth_pin !== 16'd1111 || auth_acc_num !== 4'd9) $display("FAIL lock_req%0d actual=%0d/%0d required=1111/9", i, auth_pin, auth_acc_num); else pass_cnt++;
      tick();
      respond(1'b0);
      exp_att = 2'(2 - i);
      total++; if (attempts_left !== exp_att) $display("FAIL lock_att%0d actual=%0d required=%0d", i, attempts_left, exp_att); else pass_cnt++;
      total++; if (digit_count !== 3'd0 || auth_req !== 1'b0) $display("FAIL lock_clear%0d actual=%0d/%0d required=0/0", i, digit_count, auth_req); else pass_cnt++;
    end
    tick();
    total++; if (locked_out !== 1'b1) $display("FAIL lock_flag actual=%0d required=1", locked_out); else pass_cnt++;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); enter();
    total++; if (auth_req !== 1'b0 || digit_count !== 3'd0) $display("FAIL lock_keys actual=%0d/%0d required=0/0", auth_req, digit_count); else pass_cnt++;
    remove();
    total++; if (locked_out !== 1'b0 || attempts_left !== 2'd3) $display("FAIL lock_remove actual=%0d/%0d required=0/3", locked_out, attempts_left); else pass_cnt++;
  endtask

  task automatic test_bad_card();
    logic seen_req;
    seen_req = 1'b0;
    insert(4'd12);
    tick();
    total++; if (locked_out !== 1'b1) $display("FAIL badcard_lock actual=%0d required=1", locked_out); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      press(4'd1);
      if (auth_req) seen_req = 1'b1;
    end
    enter();
    if (auth_req) seen_req = 1'b1;
    total++; if (seen_req !== 1'b0) $display("FAIL badcard_req actual=%0d required=0", seen_req); else pass_cnt++;
    remove();
  endtask

  task automatic test_key_edit();
    insert(4'd3);
    press(4'd7); press(4'd8);
    key_clear = 1'b1; tick(); key_clear = 1'b0;
    total++; if (digit_count !== 3'd0) $display("FAIL edit_clear actual=%0d required=0", digit_count); else pass_cnt++;
    press(4'd7); press(4'd1); press(4'd11);
    total++; if (digit_count !== 3'd2) $display("FAIL edit_bad_digit actual=%0d required=2", digit_count); else pass_cnt++;
    press(4'd2); press(4'd3); press(4'd5);
    total++; if (digit_count !== 3'd4) $display("FAIL edit_fifth actual=%0d required=4", digit_count); else pass_cnt++;
    enter();
    total++; if (auth_req !== 1'b1 || auth_pin !== 16'd7123) $display("FAIL edit_pin actual=%0d/%0d required=1/7123", auth_req, auth_pin); else pass_cnt++;
    total++; if (auth_acc_num !== 4'd3) $display("FAIL edit_acc actual=%0d required=3", auth_acc_num); else pass_cnt++;
    respond(1'b0);
    press(4'd1); press(4'd2); press(4'd3);
    enter();
    total++; if (auth_req !== 1'b0 || digit_count !== 3'd3) $display("FAIL edit_short_enter actual=%0d/%0d required=0/3", auth_req, digit_count); else pass_cnt++;
    key_clear = 1'b1; key_valid = 1'b1; key_digit = 4'd9;
    tick();
    key_clear = 1'b0; key_valid = 1'b0;
    total++; if (digit_count !== 3'd0) $display("FAIL edit_clear_digit actual=%0d required=0", digit_count); else pass_cnt++;
    press(4'd4); press(4'd3); press(4'd2); press(4'd1);
    key_enter = 1'b1; key_valid = 1'b1; key_digit = 4'd6;
    tick();
    key_enter = 1'b0; key_valid = 1'b0;
    total++; if (auth_req !== 1'b1 || auth_pin !== 16'd4321) $display("FAIL edit_enter_digit actual=%0d/%0d required=1/4321", auth_req, auth_pin); else pass_cnt++;
    remove();
  endtask

  task automatic test_timeout();
    int cycles;
    insert(4'd5);
    press(4'd0); press(4'd0); press(4'd4); press(4'd2);
    enter();
    total++; if (auth_pin !== 16'd42) $display("FAIL tmo_pin actual=%0d required=42", auth_pin); else pass_cnt++;
    cycles = 0;
    while (auth_req === 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
    total++; if (cycles !== 16) $display("FAIL tmo_cycles actual=%0d required=16", cycles); else pass_cnt++;
    total++; if (attempts_left !== 2'd2 || digit_count !== 3'd0) $display("FAIL tmo_state actual=%0d/%0d required=2/0", attempts_left, digit_count); else pass_cnt++;
    press(4'd8);
    total++; if (digit_count !== 3'd1) $display("FAIL tmo_collect actual=%0d required=1", digit_count); else pass_cnt++;
    remove();
  endtask

  task automatic test_card_pull();
    insert(4'd2);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    enter();
    tick();
    card_valid = 1'b0;
    respond(1'b1);
    total++; if (auth_req !== 1'b0 || auth_pin !== 16'd0) $display("FAIL pull_req actual=%0d/%0d required=0/0", auth_req, auth_pin); else pass_cnt++;
    tick(); tick();
    total++; if (session_valid !== 1'b0) $display("FAIL pull_session actual=%0d required=0", session_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    insert(4'd1);
    press(4'd5); press(4'd6);
    total++; if (digit_count !== 3'd2) $display("FAIL rstmid_pre actual=%0d required=2", digit_count); else pass_cnt++;
    rst = 1'b1; card_valid = 1'b0;
    tick();
    total++; if (digit_count !== 3'd0 || attempts_left !== 2'd3) $display("FAIL rstmid_state actual=%0d/%0d required=0/3", digit_count, attempts_left); else pass_cnt++;
    rst = 1'b0;
    tick();
    insert(4'd6);
    press(4'd9); press(4'd9); press(4'd9); press(4'd9);
    enter();
    total++; if (auth_pin !== 16'd9999) $display("FAIL rstmid_pin actual=%0d required=9999", auth_pin); else pass_cnt++;
    rst = 1'b1;
    tick();
    total++; if (auth_req !== 1'b0 || auth_pin !== 16'd0) $display("FAIL rstmid_req actual=%0d/%0d required=0/0", auth_req, auth_pin); else pass_cnt++;
    rst = 1'b0;
    respond(1'b1);
    tick(); tick();
    total++; if (session_valid !== 1'b0) $display("FAIL rstmid_late_done actual=%0d required=0", session_valid); else pass_cnt++;
    card_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; card_valid = 1'b0; card_acc_num = '0;
    key_valid = 1'b0; key_digit = '0; key_enter = 1'b0; key_clear = 1'b0;
    auth_done = 1'b0; auth_ok = 1'b0;
    test_reset();
    test_grant();
    test_lockout();
    test_bad_card();
    test_key_edit();
    test_timeout();
    test_card_pull();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
